// File: rtl/hnf_pcrdgnt_sched.sv
// ---------------------------------------------------------------------------
// hnf_pcrdgnt_sched
//
// HN-F protocol-credit grant scheduler. Every requester that was sent a
// RetryAck is queued here. When a free MSHR P-credit exists, the oldest
// queued request is offered to the TXRSP arbiter as a PCrdGrant. Only one
// grant is outstanding at a time, and the arbiter's `won` pulse completes the
// handshake.
//
// Optional feature macro: HNF_PCRDGNT_QOS_PRIO_EN
//   When this macro is defined, a second pending FIFO holds retries whose QoS
//   is at or above HI_QOS_THRESH. That FIFO is always served first. When it is
//   undefined, every retry goes through the single normal FIFO in arrival
//   order.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   retry_valid           pulse: a RetryAck was issued this cycle
//   retry_srcid[10:0]     requester node ID, which becomes the grant target
//   retry_qos[3:0]        QoS of the retried request
//   retry_pcrdtype[3:0]   PCrdType carried in the RetryAck
//   crd_return            pulse: an MSHR entry was returned to the P-credit pool
//   pcrdgnt_valid_s2      PCrdGrant request to TXRSP
//   pcrdgnt_qos_s2        grant QoS
//   pcrdgnt_tgtid_s2      grant target ID
//   pcrdgnt_pcrdtype_s2   grant PCrdType
//   pcrdgnt_won_s2        TXRSP accepted the grant this cycle
//   pend_cnt[4:0]         total pending entries across the FIFOs
//   crd_cnt[3:0]          current free P-credits
//   pend_ovf              sticky: a retry was dropped because its FIFO was full
// ---------------------------------------------------------------------------
module hnf_pcrdgnt_sched #(
  parameter int         PEND_DEPTH    = 8,
  parameter int         CRD_INIT      = 4,
  parameter int         CRD_MAX       = 15,
  parameter logic [3:0] HI_QOS_THRESH = 4'd12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retry_valid,
  input  logic [10:0] retry_srcid,
  input  logic [3:0]  retry_qos,
  input  logic [3:0]  retry_pcrdtype,
  input  logic        crd_return,
  output logic        pcrdgnt_valid_s2,
  output logic [3:0]  pcrdgnt_qos_s2,
  output logic [10:0] pcrdgnt_tgtid_s2,
  output logic [3:0]  pcrdgnt_pcrdtype_s2,
  input  logic        pcrdgnt_won_s2,
  output logic [4:0]  pend_cnt,
  output logic [3:0]  crd_cnt,
  output logic        pend_ovf
);

  localparam int AW = $clog2(PEND_DEPTH);
  localparam int EW = 19;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e         state_q;
  logic           selHi_q;
  logic           valid_q;
  logic [3:0]     qos_q;
  logic [10:0]    tgt_q;
  logic [3:0]     type_q;
  logic [3:0]     crd_q;
  logic [4:0]     pendCnt_q;
  logic           ovf_q;

  logic [EW-1:0]  retryEntry;
  logic           grantDone;

  // Each entry is packed as {srcid, qos, pcrdtype}.
  assign retryEntry = {retry_srcid, retry_qos, retry_pcrdtype};

  // A grant completes only on `won` while in ISSUE. A `won` seen in IDLE is
  // a protocol error and is ignored.
  assign grantDone = (state_q == ISSUE) && pcrdgnt_won_s2;

  // -------------------------------------------------------------------------
  // Normal pending FIFO
  // -------------------------------------------------------------------------
  logic [EW-1:0]  normMem_q [PEND_DEPTH];
  logic [AW:0]    normWr_q;
  logic [AW:0]    normRd_q;
  logic           normEmpty;
  logic           normFull;
  logic [EW-1:0]  normHead;
  logic           normPushReq;
  logic           normPush;
  logic           normPop;
  logic           normDrop;

  logic           retryHi;
  logic           hiEmpty;
  logic [EW-1:0]  hiHead;
  logic           hiPush;
  logic           hiPop;
  logic           hiDrop;

  // The pointers carry an extra wrap bit. When the index bits match, the FIFO
  // is full if the wrap bits differ and empty if they are equal.
  assign normEmpty   = (normWr_q == normRd_q);
  assign normFull    = (normWr_q[AW] != normRd_q[AW]) &&
                       (normWr_q[AW-1:0] == normRd_q[AW-1:0]);
  assign normHead    = normMem_q[normRd_q[AW-1:0]];
  assign normPushReq = retry_valid && !retryHi;
  assign normPop     = grantDone && !selHi_q;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign normPush    = normPushReq && (!normFull || normPop);
  assign normDrop    = normPushReq && normFull && !normPop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      normWr_q <= '0;
      normRd_q <= '0;
    end else begin
      if (normPush) normWr_q <= normWr_q + 1'b1;
      if (normPop)  normRd_q <= normRd_q + 1'b1;
    end
  end

  // Storage is not reset. An entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (normPush) normMem_q[normWr_q[AW-1:0]] <= retryEntry;
  end

  // -------------------------------------------------------------------------
  // High-priority pending FIFO (only when the QoS feature is built)
  // -------------------------------------------------------------------------
`ifdef HNF_PCRDGNT_QOS_PRIO_EN
  logic [EW-1:0]  hiMem_q [PEND_DEPTH];
  logic [AW:0]    hiWr_q;
  logic [AW:0]    hiRd_q;
  logic           hiFull;
  logic           hiPushReq;

  assign retryHi   = (retry_qos >= HI_QOS_THRESH);
  assign hiEmpty   = (hiWr_q == hiRd_q);
  assign hiFull    = (hiWr_q[AW] != hiRd_q[AW]) &&
                     (hiWr_q[AW-1:0] == hiRd_q[AW-1:0]);
  assign hiHead    = hiMem_q[hiRd_q[AW-1:0]];
  assign hiPushReq = retry_valid && retryHi;
  assign hiPop     = grantDone && selHi_q;
  assign hiPush    = hiPushReq && (!hiFull || hiPop);
  assign hiDrop    = hiPushReq && hiFull && !hiPop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiWr_q <= '0;
      hiRd_q <= '0;
    end else begin
      if (hiPush) hiWr_q <= hiWr_q + 1'b1;
      if (hiPop)  hiRd_q <= hiRd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hiPush) hiMem_q[hiWr_q[AW-1:0]] <= retryEntry;
  end
`else
  // The threshold has no effect in this build. It is tied to a sink only so
  // that it is referenced.
  logic [3:0] unused_hiThresh;

  assign unused_hiThresh = HI_QOS_THRESH;
  assign retryHi         = 1'b0;
  assign hiEmpty         = 1'b1;
  assign hiHead          = '0;
  assign hiPush          = 1'b0;
  assign hiPop           = 1'b0;
  assign hiDrop          = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Grant FSM with registered outputs
  // -------------------------------------------------------------------------
  // A grant is loaded only when a credit is free, so the counter cannot
  // underflow. selHi_q records which FIFO the loaded head came from, so that
  // `won` pops the same entry. The payload is frozen for the whole of ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      selHi_q <= 1'b0;
      valid_q <= 1'b0;
      qos_q   <= '0;
      tgt_q   <= '0;
      type_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (crd_q != 4'd0) begin
            if (!hiEmpty) begin
              {tgt_q, qos_q, type_q} <= hiHead;
              selHi_q <= 1'b1;
              valid_q <= 1'b1;
              state_q <= ISSUE;
            end else if (!normEmpty) begin
              {tgt_q, qos_q, type_q} <= normHead;
              selHi_q <= 1'b0;
              valid_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (pcrdgnt_won_s2) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // P-credit counter
  // -------------------------------------------------------------------------
  // A return and a grant in the same cycle cancel out. A return saturates at
  // CRD_MAX. The zero guard on decrement is defensive only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crd_q <= 4'(CRD_INIT);
    end else if (crd_return && !grantDone) begin
      if (crd_q != 4'(CRD_MAX)) crd_q <= crd_q + 4'd1;
    end else if (grantDone && !crd_return) begin
      if (crd_q != 4'd0) crd_q <= crd_q - 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Pending count and sticky overflow flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendCnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pendCnt_q <= pendCnt_q + 5'(normPush) + 5'(hiPush)
                             - 5'(normPop)  - 5'(hiPop);
      if (normDrop || hiDrop) ovf_q <= 1'b1;
    end
  end

  assign pcrdgnt_valid_s2    = valid_q;
  assign pcrdgnt_qos_s2      = qos_q;
  assign pcrdgnt_tgtid_s2    = tgt_q;
  assign pcrdgnt_pcrdtype_s2 = type_q;
  assign pend_cnt            = pendCnt_q;
  assign crd_cnt             = crd_q;
  assign pend_ovf            = ovf_q;

endmodule
